// File: rtl/mem_bus_pkg.sv
// Shared types and constants for the memory-stage bus controller.
package mem_bus_pkg;

  // Controller states; the encoding is visible on the debug state output.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // Address parked on the RAM between accesses. It lies outside the RAM,
  // so every new access is seen by the RAM as an address change.
  localparam logic [31:0] PARK_ADDR_DEFAULT = 32'hFFFF_FFFF;

  // Word-address width of data_ram (32 words).
  localparam int RAM_WORD_BITS = 5;

endpackage

// File: rtl/mem_bus_ctrl_if.sv
// CPU-side and RAM-side signals of the memory-stage bus controller.
//
// Handshake: the CPU presents a request by holding cpu_req (with cpu_we,
// cpu_addr, cpu_wdata) high; the request is retired in the one cycle where
// cpu_req is high and cpu_stall is low, and cpu_rdata is valid from that
// cycle. On the RAM side the controller holds ram_cs, ram_addr, ram_din and
// ram_we stable until ram_ack is seen high on a rising clock edge.
interface mem_bus_ctrl_if;
  logic        cpu_req;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wdata;
  logic [31:0] cpu_rdata;
  logic        cpu_stall;
  logic [31:0] ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic        ram_cs;
  logic [31:0] ram_dout;
  logic        ram_ack;
  logic        mem_err;

  // Controller view.
  modport master (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout, ram_ack,
    output cpu_rdata, cpu_stall, ram_addr, ram_din, ram_we, ram_cs, mem_err
  );

  // CPU / RAM environment view.
  modport slave (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout, ram_ack,
    input  cpu_rdata, cpu_stall, ram_addr, ram_din, ram_we, ram_cs, mem_err
  );
endinterface

// File: rtl/mem_bus_ctrl.sv
// Memory-stage bus controller: latches a CPU load/store, holds it on the
// multicycle RAM until ack (or timeout), stalls the pipeline meanwhile and
// returns registered read data. The RAM address is parked between accesses
// so that repeated accesses to one address still restart the RAM's count.
module mem_bus_ctrl
  import mem_bus_pkg::*;
#(
  parameter int          TIMEOUT   = 32,
  parameter logic [31:0] PARK_ADDR = PARK_ADDR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  mem_bus_ctrl_if.master bus,
  output state_t        dbg_state
);

  localparam int TW = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TMAX  = '1;

  state_t        state_q;
  state_t        state_d;
  logic [31:0]   addr_q;
  logic          we_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic [TW-1:0] tcnt;
  logic          err_q;
  logic          timeout_hit;

  assign timeout_hit = (tcnt == TLAST);

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: one BUSY period per request, then a single DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.cpu_req) state_d = BUSY;
      BUSY:    if (bus.ram_ack || timeout_hit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, timeout counter, read-data register and sticky error.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= PARK_ADDR;
      we_q    <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      tcnt    <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.cpu_req) begin
            addr_q  <= bus.cpu_addr;
            we_q    <= bus.cpu_we;
            wdata_q <= bus.cpu_wdata;
            tcnt    <= '0;
          end
        end
        BUSY: begin
          // Saturate so a stuck counter can never wrap back below TLAST.
          if (tcnt != TMAX) tcnt <= tcnt + TW'(1);
          if (bus.ram_ack) begin
            if (!we_q) rdata_q <= bus.ram_dout;
            addr_q <= PARK_ADDR;
          end else if (timeout_hit) begin
            err_q   <= 1'b1;
            rdata_q <= '0;
            addr_q  <= PARK_ADDR;
          end
        end
        default: addr_q <= PARK_ADDR;
      endcase
    end
  end

  // RAM side is driven only from registers and decoded state.
  always_comb begin
    bus.ram_addr  = addr_q;
    bus.ram_din   = wdata_q;
    bus.ram_cs    = (state_q == BUSY);
    bus.ram_we    = we_q & (state_q == BUSY);
    bus.cpu_stall = bus.cpu_req & (state_q != DONE);
    bus.cpu_rdata = rdata_q;
    bus.mem_err   = err_q;
  end

  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// Self-checking bench for mem_bus_ctrl with a behavioural 8-negedge RAM.
module tb_mem_bus_ctrl;
  import mem_bus_pkg::*;

  localparam int          TIMEOUT   = 32;
  localparam logic [31:0] PARK      = 32'hFFFF_FFFF;
  localparam int          RAM_WORDS = 1 << RAM_WORD_BITS;
  localparam int          LAT_NEG   = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_bus_ctrl_if bus ();
  state_t dbg_state;

  mem_bus_ctrl #(.TIMEOUT(TIMEOUT), .PARK_ADDR(PARK)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- RAM model ----------------
  // Counter clears on any address change; ack rises on the 8th counting
  // negedge after the change-detecting one, and the access happens then.
  logic [31:0] ram_mem [RAM_WORDS] = '{3: 32'h0000_1234, 7: 32'h0000_0077, default: 32'h0};
  logic [31:0] prev_addr = 32'h0;
  int          rcnt = 0;
  bit          no_ack = 1'b0;

  always @(negedge clk) begin
    if (bus.ram_addr != prev_addr) begin
      prev_addr   <= bus.ram_addr;
      rcnt        <= 0;
      bus.ram_ack <= 1'b0;
    end else if (bus.ram_cs && !no_ack) begin
      if (rcnt == LAT_NEG - 1) begin
        rcnt        <= LAT_NEG;
        bus.ram_ack <= 1'b1;
        if (bus.ram_addr < RAM_WORDS) begin
          if (bus.ram_we) ram_mem[bus.ram_addr[RAM_WORD_BITS-1:0]] <= bus.ram_din;
          else            bus.ram_dout <= ram_mem[bus.ram_addr[RAM_WORD_BITS-1:0]];
        end else begin
          bus.ram_dout <= 32'h0;
        end
      end else if (rcnt < LAT_NEG - 1) begin
        rcnt <= rcnt + 1;
      end
    end
  end

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [RAM_WORDS] = '{3: 32'h0000_1234, 7: 32'h0000_0077, default: 32'h0};
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  logic        exp_err    = 1'b0;
  int          checks     = 0;
  int          errors     = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge with the controller idle. Drives one
  // request, follows it to the release cycle and checks it there.
  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] exp_rd;
    logic [31:0] bad_val;
    bit          hold_bad;
    bit          released;
    int          stalls, cs_cycles, we_cycles, exp_stalls;
    bit          tmo;

    tmo        = no_ack;
    exp_stalls = tmo ? TIMEOUT + 1 : LAT_NEG + 2;
    if (tmo)     exp_rd = 32'h0;
    else if (we) exp_rd = last_rdata;
    else         exp_rd = (addr < RAM_WORDS) ? ref_mem[addr[RAM_WORD_BITS-1:0]] : 32'h0;
    if (!tmo && we && addr < RAM_WORDS) ref_mem[addr[RAM_WORD_BITS-1:0]] = wdata;
    if (tmo) exp_err = 1'b1;
    exp_q.push_back(exp_rd);

    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wdata;

    stalls = 0; cs_cycles = 0; we_cycles = 0;
    hold_bad = 1'b0; bad_val = 32'h0; released = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!bus.cpu_stall) begin
        released = 1'b1;
        break;
      end
      stalls++;
      if (bus.ram_cs) cs_cycles++;
      if (bus.ram_we) we_cycles++;
      if (bus.cpu_rdata !== last_rdata && !hold_bad) begin
        hold_bad = 1'b1;
        bad_val  = bus.cpu_rdata;
      end
    end
    check("release_seen", 32'(released), 32'd1);
    check("stall_cycles", stalls, exp_stalls);
    check("cs_cycles", cs_cycles, exp_stalls - 1);
    check("we_cycles", we_cycles, we ? exp_stalls - 1 : 0);
    check("rdata_hold", hold_bad ? bad_val : last_rdata, last_rdata);
    check("done_state", 32'(dbg_state), 32'(DONE));
    check("done_park", bus.ram_addr, PARK);
    check("done_cs", 32'(bus.ram_cs), 32'd0);
    check("rdata", bus.cpu_rdata, exp_q.pop_front());
    check("mem_err", 32'(bus.mem_err), 32'(exp_err));
    last_rdata = exp_rd;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_gap(input int n);
    bus.cpu_req = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("idle_stall", 32'(bus.cpu_stall), 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bus.cpu_req   = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_addr  = 32'h0;
    bus.cpu_wdata = 32'h0;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    check("rst_addr", bus.ram_addr, PARK);
    check("rst_cs", 32'(bus.ram_cs), 32'd0);
    check("rst_we", 32'(bus.ram_we), 32'd0);
    check("rst_din", bus.ram_din, 32'h0);
    check("rst_rdata", bus.cpu_rdata, 32'h0);
    check("rst_err", 32'(bus.mem_err), 32'd0);
    @(posedge clk);
    #1;

    // Directed: load, store then same-address load back-to-back, out-of-range,
    // and a data change across two loads.
    access(1'b0, 32'd3, 32'h0);
    idle_gap(2);
    access(1'b1, 32'd5, 32'hDEAD_BEEF);
    access(1'b0, 32'd5, 32'h0);
    idle_gap(1);
    access(1'b0, 32'h0000_0100, 32'h0);
    access(1'b0, 32'd3, 32'h0);
    access(1'b0, 32'd7, 32'h0);
    idle_gap(1);

    // Timeout, then a normal load with the error still flagged.
    no_ack = 1'b1;
    access(1'b0, 32'd2, 32'h0);
    no_ack = 1'b0;
    idle_gap(1);
    access(1'b0, 32'd3, 32'h0);
    idle_gap(1);

    // Reset during the 4th BUSY cycle.
    bus.cpu_req  = 1'b1;
    bus.cpu_we   = 1'b0;
    bus.cpu_addr = 32'd9;
    repeat (4) @(posedge clk);
    #1;
    check("busy4_cs", 32'(bus.ram_cs), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("arst_state", 32'(dbg_state), 32'(IDLE));
    check("arst_cs", 32'(bus.ram_cs), 32'd0);
    check("arst_addr", bus.ram_addr, PARK);
    check("arst_rdata", bus.cpu_rdata, 32'h0);
    check("arst_err", 32'(bus.mem_err), 32'd0);
    check("arst_stall_req1", 32'(bus.cpu_stall), 32'd1);
    bus.cpu_req = 1'b0;
    #1;
    check("arst_stall_req0", 32'(bus.cpu_stall), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    last_rdata = 32'h0;
    exp_err    = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic: in/out of range, loads/stores, occasional timeouts,
    // back-to-back or with idle gaps.
    for (int t = 0; t < 40; t++) begin
      logic        r_we;
      logic [31:0] r_addr;
      logic [31:0] r_data;
      r_we   = 1'($urandom_range(0, 1));
      r_addr = ($urandom_range(0, 9) == 0) ? 32'(RAM_WORDS + $urandom_range(0, 300))
                                           : 32'($urandom_range(0, RAM_WORDS - 1));
      r_data = $urandom;
      no_ack = ($urandom_range(0, 11) == 0);
      access(r_we, r_addr, r_data);
      no_ack = 1'b0;
      if ($urandom_range(0, 1) == 1) idle_gap($urandom_range(1, 3));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_bus_ctrl.md
Name: mem_bus_ctrl

Overview:
Memory-stage bus controller between the CPU MEM stage and the multicycle data_ram.
- Latches each CPU load/store request and holds address, data and we stable until the RAM acks.
- Stalls the pipeline while the access is in flight and returns registered read data.
- Parks the RAM address between accesses so that back-to-back accesses to the same address each restart the RAM's latency counter.

Parameters:
TIMEOUT, 32, maximum BUSY cycles without ram_ack before abort.
PARK_ADDR, 32'hFFFF_FFFF, address driven to the RAM when idle; out of RAM range, forces an address change.

Ports:
clk  in  1  system clock; controller state updates on posedge.
rst  in  1  reset, synchronous, active-high.
cpu_req  in  1  MEM stage has a load or store this cycle.
cpu_we  in  1  1 = store, 0 = load; valid with cpu_req.
cpu_addr  in  32  word address.
cpu_wdata  in  32  store data.
cpu_rdata  out  32  load data, registered.
cpu_stall  out  1  freeze pipeline; combinational.
ram_addr  out  32  to data_ram addr.
ram_din  out  32  to data_ram din.
ram_we  out  1  to data_ram we.
ram_cs  out  1  to data_ram cs.
ram_dout  in  32  from data_ram dout.
ram_ack  in  1  from data_ram ack; updated on negedge, sampled here on posedge.
mem_err  out  1  sticky timeout flag.

Behaviour:
- Reset (sync, posedge with rst=1):
  - state=IDLE; addr_q=PARK_ADDR; we_q=0; wdata_q=0.
  - rdata_q=0; tcnt=0; mem_err=0.
  - rst dominates in every state; an in-flight access is abandoned with no ack wait.
- RAM-side outputs are registered or state-decoded only:
  - ram_addr=addr_q; ram_din=wdata_q.
  - ram_we=we_q & (state==BUSY); ram_cs=(state==BUSY).
- cpu_stall = cpu_req & (state!=DONE). cpu_rdata = rdata_q.
- IDLE:
  - addr_q holds PARK_ADDR.
  - On cpu_req: latch cpu_addr, cpu_we, cpu_wdata; tcnt=0; go BUSY.
- BUSY:
  - tcnt+1 each cycle.
  - If ram_ack=1: when we_q=0, rdata_q<=ram_dout (stores leave rdata_q unchanged); go DONE.
  - Else if tcnt==TIMEOUT-1: mem_err<=1; rdata_q<=0; go DONE.
  - ack has priority over timeout in the same cycle.
- DONE (exactly one cycle):
  - stall released.
  - addr_q<=PARK_ADDR at entry, so the RAM sees an address change at this cycle's negedge and clears its counter and ack.
  - cpu_req is ignored; it is the request being retired.
  - Next state is always IDLE.
- Latency, request arriving in IDLE at cycle n, with an 8-negedge RAM:
  - BUSY n+1..n+9; DONE n+10.
  - cpu_stall high n..n+9 (10 cycles); cpu_rdata valid from n+10.
- Back-to-back:
  - The next request, same or different address, is accepted in the IDLE cycle after DONE.
  - The parked DONE cycle guarantees the RAM restarts its count.
- Address out of RAM range: no special casing. The RAM returns 0 and acks normally.
- mem_err is cleared only by rst.
- tcnt width is clog2(TIMEOUT)+1; it saturates and never wraps.

Decomposition:
- Package mem_bus_pkg:
  - state enum IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
  - PARK_ADDR default constant.
  - RAM_WORD_BITS=5, shared with data_ram ADDR_WIDTH.
- Single module; no sub-module. The timeout counter is inline.

Test Plan:
- Load addr 3, RAM word 3 = 32'h0000_1234 -> cpu_stall high 10 cycles, DONE on cycle 11, cpu_rdata=32'h0000_1234, ram_cs high exactly 9 cycles.
- Store 32'hDEAD_BEEF to addr 5, then immediately load addr 5 -> ram_addr=PARK_ADDR during the DONE cycle; second access also takes 10 stall cycles; cpu_rdata=32'hDEAD_BEEF.
- ram_ack forced 0, load addr 2 -> DONE after exactly TIMEOUT=32 BUSY cycles, mem_err=1 and stays 1, cpu_rdata=0; the next normal load succeeds with mem_err still 1.
- rst asserted on the 4th BUSY cycle -> next posedge state=IDLE, ram_cs=0, ram_addr=PARK_ADDR, cpu_rdata=0, mem_err=0; cpu_stall follows cpu_req.
- Load addr 32'h0000_0100 (out of range) -> normal 10-cycle stall, cpu_rdata=0, mem_err=0.
- Load addr 7 (=32'h0000_0077) after a load addr 3 (=32'h0000_1234) -> cpu_rdata holds 32'h0000_1234 until the second access's DONE, then 32'h0000_0077.
